// File: rtl/disp_7seg_scan_if.sv
// Display-side bundle for disp_7seg_scan: digit data and controls in, anode/segment drive out,
// plus the scan position (idx/sub) for observation.
interface disp_7seg_scan_if #(
  parameter int DIGITS = 8,
  parameter int BW     = 3
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // No handshake: CE is a plain one-cycle tick that qualifies every state update.
  // EO/Q are continuously valid registered levels with no ready path back.
  logic                  CE;
  logic [DIGITS-1:0]     E;
  logic [DIGITS-1:0]     DP;
  logic [4*DIGITS-1:0]   IN;
  logic [BW-1:0]         BRIGHT;
  logic [DIGITS-1:0]     EO;
  logic [7:0]            Q;
  logic [IDXW-1:0]       dbg_idx;
  logic [BW-1:0]         dbg_sub;

  modport master (
    output CE, E, DP, IN, BRIGHT,
    input  EO, Q, dbg_idx, dbg_sub
  );

  modport slave (
    input  CE, E, DP, IN, BRIGHT,
    output EO, Q, dbg_idx, dbg_sub
  );
endinterface

// File: rtl/disp_7seg_scan.sv
// Multiplexed common-anode 7-segment scan driver with per-slot PWM dimming and a blank guard.
// Optional leading-zero suppression is enabled by defining DISP_LZ_BLANK_EN.
module disp_7seg_scan #(
  parameter int DIGITS = 8,
  parameter int BW     = 3
) (
  input  logic               CLK,
  input  logic               CLR,
  disp_7seg_scan_if.slave    bus
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [BW-1:0]   SUB_LAST = '1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

  // Active-low glyphs, bit order g..a.
  function automatic logic [6:0] seg7_n(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [IDXW-1:0]   r_idx;
  logic [BW-1:0]     r_sub;
  logic [3:0]        r_h_nib;
  logic              r_h_dp;
  logic              r_h_en;
  logic              r_h_blank;
  logic [DIGITS-1:0] r_eo;
  logic [7:0]        r_q;

  logic              w_slot_end;
  logic              w_load;
  logic [IDXW-1:0]   w_idx_next;
  logic [IDXW-1:0]   w_ld_idx;
  logic [3:0]        w_ld_nib;
  logic              w_ld_dp;
  logic              w_ld_en;
  logic              w_ld_blank;
  logic [DIGITS-1:0] w_lz_sup;
  logic              w_on;
  logic [DIGITS-1:0] w_eo_on;
  logic [6:0]        w_seg;

  always_comb begin
    w_slot_end = (r_sub == SUB_LAST);
    w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    w_load     = CLR || (bus.CE && w_slot_end);
    w_ld_idx   = CLR ? '0 : w_idx_next;
  end

`ifdef DISP_LZ_BLANK_EN
  // Walk from the top digit down; a zero digit is suppressed while every enabled digit above it
  // is also zero. Digit 0 always shows.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    w_lz_sup   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_lz_sup[i] = (i != 0) && (bus.IN[4*i +: 4] == 4'h0) && upper_zero;
      if (!bus.E[i] && (bus.IN[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end
`else
  assign w_lz_sup = '0;
`endif

  always_comb begin
    w_ld_nib   = '0;
    w_ld_dp    = 1'b0;
    w_ld_en    = 1'b0;
    w_ld_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_ld_idx == IDXW'(i)) begin
        w_ld_nib   = bus.IN[4*i +: 4];
        w_ld_dp    = bus.DP[i];
        w_ld_en    = ~bus.E[i];
        w_ld_blank = w_lz_sup[i];
      end
    end
  end

  // Sub-tick 0 of every slot is the anti-ghosting guard; BRIGHT is used live, not latched.
  always_comb begin
    w_on    = r_h_en && (r_sub != '0) && (r_sub <= bus.BRIGHT);
    w_eo_on = ~(DIGITS'(1) << r_idx);
    w_seg   = r_h_blank ? 7'h7F : seg7_n(r_h_nib);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_idx <= '0;
      r_sub <= '0;
    end else if (bus.CE) begin
      r_sub <= r_sub + 1'b1;
      if (w_slot_end) r_idx <= w_idx_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_h_nib <= w_ld_nib;
      r_h_dp  <= w_ld_dp;
      r_h_en  <= w_ld_en;
`ifdef DISP_LZ_BLANK_EN
      r_h_blank <= w_ld_blank;
`else
      r_h_blank <= 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_eo <= '1;
      r_q  <= 8'hFF;
    end else begin
      r_eo <= w_on ? w_eo_on : '1;
      r_q  <= w_on ? {~r_h_dp, w_seg} : 8'hFF;
    end
  end

  assign bus.EO      = r_eo;
  assign bus.Q       = r_q;
  assign bus.dbg_idx = r_idx;
  assign bus.dbg_sub = r_sub;

  logic w_unused;
  assign w_unused = w_ld_blank;
endmodule

// File: tb/tb_disp_7seg_scan.sv
// Directed bench for disp_7seg_scan with DIGITS=4, BW=2 (4 CE ticks per slot).
module tb_disp_7seg_scan;
  logic clk;
  logic clr;
  int   checks;
  int   failures;

  disp_7seg_scan_if #(.DIGITS(4), .BW(2)) bus ();

  disp_7seg_scan #(.DIGITS(4), .BW(2)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [7:0] G0 = 8'b11000000;
  localparam logic [7:0] G1 = 8'b11111001;
  localparam logic [7:0] G2 = 8'b10100100;
  localparam logic [7:0] G3 = 8'b10110000;
  localparam logic [7:0] G4 = 8'b10011001;
  localparam logic [7:0] G5 = 8'b10010010;
  localparam logic [7:0] G8 = 8'b10000000;
  localparam logic [7:0] FF = 8'hFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eo_exp, input logic [7:0] q_exp);
    checks++;
    assert (bus.EO === eo_exp) else begin
      failures++;
      $error("FAIL %s EO got=%b exp=%b", tag, bus.EO, eo_exp);
    end
    checks++;
    assert (bus.Q === q_exp) else begin
      failures++;
      $error("FAIL %s Q got=%b exp=%b", tag, bus.Q, q_exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] idx_exp, input logic [1:0] sub_exp);
    checks++;
    assert (bus.dbg_idx === idx_exp) else begin
      failures++;
      $error("FAIL %s idx got=%0d exp=%0d", tag, bus.dbg_idx, idx_exp);
    end
    checks++;
    assert (bus.dbg_sub === sub_exp) else begin
      failures++;
      $error("FAIL %s sub got=%0d exp=%0d", tag, bus.dbg_sub, sub_exp);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Runs n CE cycles after a reset; entry k-1 is the expected output after edge k.
  task automatic run_scan(input string tag, input int n,
                          input logic [3:0] eo_t[16], input logic [7:0] q_t[16]);
    for (int k = 1; k <= n; k++) begin
      step();
      chk_out($sformatf("%s_k%0d", tag, k), eo_t[(k-1) % 16], q_t[(k-1) % 16]);
    end
  endtask

  logic [3:0] eo_t[16];
  logic [7:0] q_t[16];
  logic [7:0] d2_exp;
  logic [7:0] d3_exp;

  initial begin
    checks   = 0;
    failures = 0;
    clr        = 1'b1;
    bus.CE     = 1'b1;
    bus.E      = 4'b0000;
    bus.DP     = 4'b0000;
    bus.IN     = 16'h4321;
    bus.BRIGHT = 2'd3;

    // 1: full-brightness scan with wrap back to digit 0
    do_reset();
    chk_out("rst", 4'hF, FF);
    chk_state("rst", 2'd0, 2'd0);
    eo_t = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
             4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    q_t  = '{FF, G1, G1, G1, FF, G2, G2, G2, FF, G3, G3, G3, FF, G4, G4, G4};
    run_scan("t1", 16, eo_t, q_t);
    chk_state("t1_wrap", 2'd0, 2'd0);
    run_scan("t1w", 2, eo_t, q_t);

    // 2: BRIGHT change mid-slot acts on the next clock, then BRIGHT=1 and BRIGHT=0
    do_reset();
    step(); chk_out("t2_mid_k1", 4'hF, FF);
    step(); chk_out("t2_mid_k2", 4'hE, G1);
    bus.BRIGHT = 2'd1;
    step(); chk_out("t2_mid_k3", 4'hF, FF);
    do_reset();
    eo_t = '{4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hD, 4'hF, 4'hF,
             4'hF, 4'hB, 4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF};
    q_t  = '{FF, G1, FF, FF, FF, G2, FF, FF, FF, G3, FF, FF, FF, G4, FF, FF};
    run_scan("t2_b1", 16, eo_t, q_t);
    bus.BRIGHT = 2'd0;
    do_reset();
    eo_t = '{default: 4'hF};
    q_t  = '{default: FF};
    run_scan("t2_b0", 16, eo_t, q_t);

    // 3: digit 2 disabled keeps its slot dark without shortening it
    bus.BRIGHT = 2'd3;
    bus.E      = 4'b0100;
    do_reset();
    eo_t = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
             4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7};
    q_t  = '{FF, G1, G1, G1, FF, G2, G2, G2, FF, FF, FF, FF, FF, G4, G4, G4};
    run_scan("t3", 16, eo_t, q_t);

    // 4: digit-1 data change while lit appears only in its next slot
    bus.E  = 4'b0000;
    bus.IN = 16'h4231;
    do_reset();
    for (int k = 1; k <= 6; k++) step();
    chk_out("t4_k6", 4'hD, G3);
    bus.IN = 16'h4281;
    step(); chk_out("t4_k7", 4'hD, G3);
    step(); chk_out("t4_k8", 4'hD, G3);
    for (int k = 9; k <= 21; k++) step();
    chk_out("t4_k21", 4'hF, FF);
    step(); chk_out("t4_k22", 4'hD, G8);
    step(); chk_out("t4_k23", 4'hD, G8);

    // 5: CE one cycle in three, then CLR mid-slot together with CE
    do_reset();
    eo_t = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
             4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD};
    q_t  = '{FF, G1, G1, G1, G1, G1, G1, G1, G1, G1, FF, FF, FF, G8, G8, G8};
    for (int k = 1; k <= 16; k++) begin
      bus.CE = (k % 3 == 1);
      step();
      chk_out($sformatf("t5_k%0d", k), eo_t[k-1], q_t[k-1]);
    end
    chk_state("t5_mid", 2'd1, 2'd2);
    bus.CE = 1'b1;
    clr    = 1'b1;
    step();
    chk_out("t5_clr", 4'hF, FF);
    chk_state("t5_clr", 2'd0, 2'd0);
    clr = 1'b0;
    step(); chk_out("t5_post1", 4'hF, FF);
    step(); chk_out("t5_post2", 4'hE, G1);

    // 6: leading zeros, with the expectation depending on the build option
`ifdef DISP_LZ_BLANK_EN
    d2_exp = 8'b01111111;
    d3_exp = FF;
`else
    d2_exp = 8'b01000000;
    d3_exp = G0;
`endif
    bus.IN = 16'h0050;
    bus.DP = 4'b0100;
    do_reset();
    eo_t = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
             4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    q_t  = '{FF, G0, G0, G0, FF, G5, G5, G5, FF, d2_exp, d2_exp, d2_exp,
             FF, d3_exp, d3_exp, d3_exp};
    run_scan("t6", 16, eo_t, q_t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
